// File: rtl/key_debounce_if.sv
// +--------------------------------------------------------------------------+
// | key_debounce_if : key levels in, debounced lights/strobes/priority out.  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface key_debounce_if;
  logic [7:0] key_raw;
  logic [7:0] light;
  logic [7:0] press_pulse;
  logic       key_valid;
  logic [2:0] key_code;

  modport master (
    output key_raw,
    input  light,
    input  press_pulse,
    input  key_valid,
    input  key_code
  );

  modport slave (
    input  key_raw,
    output light,
    output press_pulse,
    output key_valid,
    output key_code
  );
endinterface

`default_nettype wire

// File: rtl/key_debounce.sv
// +--------------------------------------------------------------------------+
// | key_debounce : 8-key synchronizer + per-key debounce FSM with press      |
// | strobes. Define KEY_DEBOUNCE_MONO_PRIORITY_EN for lowest-key-wins mode.  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 20
) (
  input  logic          clk,
  input  logic          rst,
  key_debounce_if.slave bus
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PEND_ON  = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;
  localparam logic [1:0] ST_PEND_OFF = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0] sync1_q, sync1_d;
  logic [7:0] sync2_q, sync2_d;
  logic [7:0] held_d;
  logic [7:0] accept_d;
  logic [7:0] light_q, light_d;
  logic [7:0] press_q, press_d;
  logic [2:0] key_code_w;

  always_comb begin
    sync1_d = bus.key_raw;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 8'd0;
      sync2_q <= 8'd0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_key
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             held_bit;
    logic             accept_bit;

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        ST_IDLE: begin
          if (sync2_q[i]) begin
            state_d = ST_PEND_ON;
            cnt_d   = '0;
          end
        end
        ST_PEND_ON: begin
          if (!sync2_q[i])           state_d = ST_IDLE;
          else if (cnt_q == CNT_LAST) state_d = ST_HELD;
          else                       cnt_d   = cnt_q + 1'b1;
        end
        ST_HELD: begin
          if (!sync2_q[i]) begin
            state_d = ST_PEND_OFF;
            cnt_d   = '0;
          end
        end
        ST_PEND_OFF: begin
          if (sync2_q[i])            state_d = ST_HELD;
          else if (cnt_q == CNT_LAST) state_d = ST_IDLE;
          else                       cnt_d   = cnt_q + 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Light tracks the next state so it rises on the same edge as HELD entry.
    always_comb begin
      held_bit   = (state_d == ST_HELD) || (state_d == ST_PEND_OFF);
      accept_bit = (state_q == ST_PEND_ON) && (state_d == ST_HELD);
    end

    assign held_d[i]   = held_bit;
    assign accept_d[i] = accept_bit;
  end

`ifdef KEY_DEBOUNCE_MONO_PRIORITY_EN
  // Lowest held key wins; a press is masked if any lower key is held now.
  always_comb begin
    light_d = held_d & (~held_d + 8'd1);
    press_d = 8'd0;
    for (int k = 0; k < 8; k++) begin
      press_d[k] = accept_d[k] && ((held_d & ((8'd1 << k) - 8'd1)) == 8'd0);
    end
  end
`else
  always_comb begin
    light_d = held_d;
    press_d = accept_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      light_q <= 8'd0;
      press_q <= 8'd0;
    end else begin
      light_q <= light_d;
      press_q <= press_d;
    end
  end

  always_comb begin
    key_code_w = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (light_q[k]) key_code_w = 3'(k);
    end
  end

  assign bus.light       = light_q;
  assign bus.press_pulse = press_q;
  assign bus.key_valid   = |light_q;
  assign bus.key_code    = key_code_w;

endmodule

`default_nettype wire

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000, giving the stable-sample count required to accept an edge (1 ms at 50 MHz); legal range 2 to 2^CNT_W-1.
REQ-002 The block SHALL have parameter CNT_W, default 20, giving the debounce counter width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is clocked on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port key_raw, input, 8 bits: raw asynchronous piano key/sensor levels, bit 0 = lowest note, 1 = pressed.
REQ-006 The block SHALL have port light, output, 8 bits: debounced per-key level that drives the tone-generator enable inputs.
REQ-007 The block SHALL have port press_pulse, output, 8 bits: one-cycle strobe per key on an accepted press.
REQ-008 The block SHALL have port key_valid, output, 1 bit: high when any light bit is high.
REQ-009 The block SHALL have port key_code, output, 3 bits: index of the lowest-numbered set light bit, 0 when key_valid is 0.

Function
REQ-010 Each key_raw bit SHALL pass through a two-flop synchronizer; its second-stage output is "sync".
REQ-011 Each key SHALL own an independent FSM with states IDLE, PEND_ON, HELD and PEND_OFF, plus a CNT_W-bit counter.
REQ-012 In IDLE with sync=1, the FSM SHALL go to PEND_ON and clear the counter; with sync=0 it SHALL stay in IDLE.
REQ-013 In PEND_ON with sync=0, the FSM SHALL return to IDLE; with sync=1 and counter=DEBOUNCE_CYCLES-1 it SHALL go to HELD; otherwise it SHALL increment the counter.
REQ-014 In HELD with sync=0, the FSM SHALL go to PEND_OFF and clear the counter; with sync=1 it SHALL stay in HELD.
REQ-015 In PEND_OFF with sync=1, the FSM SHALL return to HELD; with sync=0 and counter=DEBOUNCE_CYCLES-1 it SHALL go to IDLE; otherwise it SHALL increment the counter.
REQ-016 Each light bit SHALL be a registered output that is 1 exactly when its FSM is in HELD or PEND_OFF.
REQ-017 Latency: after key_raw rises and stays stable, light SHALL rise on the (DEBOUNCE_CYCLES+3)th rising clk edge; release SHALL use the same latency.
REQ-018 press_pulse[i] SHALL be high for exactly the one cycle following the PEND_ON-to-HELD transition of key i; a PEND_OFF-to-HELD return SHALL NOT pulse.
REQ-019 Any glitch shorter than DEBOUNCE_CYCLES+1 synchronized samples SHALL leave light unchanged.
REQ-020 Keys SHALL be fully independent: simultaneous presses on several keys SHALL each complete on their own timing.
REQ-021 key_valid and key_code SHALL be combinational from the light register and add no latency.
REQ-022 The counter SHALL never wrap, because every increment is bounded by the DEBOUNCE_CYCLES-1 compare.

Reset
REQ-023 While rst=1 at a clk edge, all synchronizer flops, counters, light and press_pulse SHALL clear to 0, and all FSMs SHALL enter IDLE.
REQ-024 Asserting rst mid-debounce or mid-hold SHALL drop light on the next edge; a key still held after rst is released SHALL go through the full press debounce again.
REQ-025 key_valid SHALL be 0 and key_code SHALL be 0 during reset.

Configuration
REQ-026 When macro KEY_DEBOUNCE_MONO_PRIORITY_EN is defined, light SHALL be one-hot at the key_code position (monophonic, lowest key wins), computed internally from the unmasked held set.
REQ-027 When KEY_DEBOUNCE_MONO_PRIORITY_EN is defined, press_pulse[i] SHALL be suppressed if a lower-index key is already held.
REQ-028 When KEY_DEBOUNCE_MONO_PRIORITY_EN is undefined, light SHALL reflect all held keys (polyphonic), and press_pulse SHALL be unmasked.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 Bench: key_raw=8'h10 held from edge 0 -> light=8'h10 after edge 7, press_pulse=8'h10 for one cycle, key_code=4, key_valid=1.
REQ-030 Bench: key_raw[0] high for 3 cycles, then low -> light, press_pulse and key_valid remain 0 throughout.
REQ-031 Bench: key G held, then a 2-cycle low dropout -> light stays 1 and no second press_pulse occurs; a stable release -> light falls 7 edges after key_raw falls.
REQ-032 Bench: key_raw=8'h0A simultaneously -> light=8'h0A and key_code=1 (mono build: light=8'h02, press_pulse=8'h02 only).
REQ-033 Bench: rst=1 for 1 cycle while light=8'h10 with key still held -> light=0 on the next edge, then light=8'h10 again 7 edges after rst deasserts.
REQ-034 Bench: key 3 held, then key 1 pressed in a mono build -> light moves from 8'h08 to 8'h02, and press_pulse[1] fires.
